lbm_moment_ram: RTL and testbench
=================================

# lbm_moment_ram

Single-port synchronous RAM that holds one per-node macroscopic moment (density or a velocity component) for the LBM lattice. The default depth is one word per node of a 16x16 grid. The collision/streaming datapath writes computed moments into it and reads them back for equilibrium and display. After reset it zero-fills its whole array by itself, so no node ever reads uninitialised data.

## Interface
Parameters:
- DEPTH, 256 (16*16): number of words, one per lattice node.
- ADDRESS_WIDTH, $clog2(DEPTH): width of `address`.
- DATA_WIDTH, 32: moment word width, two's-complement signed.

Ports:
- Clk  input  1: system clock (50 MHz); all state changes on the rising edge.
- Reset  input  1: asynchronous, active-high reset.
- WE  input  1: write enable, sampled on the rising edge of Clk.
- address  input  ADDRESS_WIDTH: word address for both read and write.
- data_in  input  signed DATA_WIDTH: write data.
- data_out  output  signed DATA_WIDTH: registered read data.
- Init_Done  output  1: high once the post-reset zero-fill has completed.

## Operation
- Storage: DEPTH x DATA_WIDTH array, inferable as on-chip block RAM. There is no per-word reset; contents are cleared only by the init sweep.
- Reset is asserted (asynchronous):
  - data_out = 0, Init_Done = 0.
  - Internal sweep pointer = 0; FSM enters INIT.
- INIT state:
  - Each Clk writes 0 to mem[pointer], then increments the pointer.
  - External WE, address and data_in are ignored.
  - data_out is held at 0.
  - After the write to address DEPTH-1, the FSM moves to RUN and Init_Done rises on that same edge.
- RUN state (Init_Done = 1), on each rising edge:
  - If WE = 1 and address < DEPTH: mem[address] <= data_in, and data_out <= data_in (write-first / write-through).
  - If WE = 0 and address < DEPTH: data_out <= mem[address].
  - If address >= DEPTH (only possible when DEPTH is not a power of two): the write is discarded and data_out <= 0.
- Data is stored and returned bit-exact. There is no sign extension or arithmetic; signedness only tags the port type.
- Reset asserted mid-INIT or mid-RUN: the sweep restarts from address 0. Any contents written before the reset are lost once the sweep passes them.

## Timing
- Read latency: 1 cycle. An address presented before edge N appears on data_out after edge N.
- Write: takes effect at the edge where WE = 1. A read of the same address at the next edge returns the new value.
- Write-first: during a write cycle, data_out shows data_in after the same edge.
- Init duration: exactly DEPTH cycles after Reset deasserts; Init_Done goes high after the DEPTH-th rising edge.
- Reset effect is immediate and does not wait for Clk. Deassertion is expected to be synchronised to Clk upstream.
- No handshake: one access per cycle at full clock rate, back-to-back reads and writes allowed, no stalls.

## Test plan
- Reset then idle: assert Reset at t=0, release. Expect data_out = 0 and Init_Done = 0 for 256 cycles, then Init_Done = 1. Reading any address afterwards returns 0.
- Sequential write: WE = 1 with data_in = 1 at addresses 0x00, 0x01, 0x02, 0x03 on consecutive cycles. Expect data_out = 1 after each edge. Then WE = 0 and read 0x00–0x03: each returns 1; 0x04 returns 0.
- Signed and full-width data: write 32'h1234_5678 to 0x12 and 32'hABCC_CDEF (negative) to 0xFF. Read both back exactly, 1 cycle after each address is presented.
- Writes during INIT: hold WE = 1, address = 0x05, data_in = 0xDEAD_BEEF throughout the sweep. After Init_Done, mem[0x05] reads 0.
- Reset mid-operation: write 7 to 0x10, assert Reset asynchronously between clock edges. data_out = 0 immediately, Init_Done = 0, a full 256-cycle sweep follows, and 0x10 then reads 0.
- Read/write interleave: write A to 0x20, then read 0x20 on the next cycle, then write B to 0x20, then read. Returns A, then B, each with 1-cycle latency.

Source files
------------

// File: rtl/lbm_moment_ram.sv
// lbm_moment_ram
// Single-port synchronous RAM that holds one macroscopic moment (density or a
// velocity component) per lattice node. After reset it zero-fills the whole
// array by itself, one word per cycle, before it accepts external accesses.
//
// Ports:
//   Clk        system clock; all state changes on the rising edge
//   Reset      asynchronous, active-high reset; restarts the zero-fill sweep
//   WE         write enable (honoured only once Init_Done is high)
//   address    word address for both read and write
//   data_in    write data (stored bit-exact)
//   data_out   registered read data, 1-cycle latency, write-first on writes
//   Init_Done  high once the post-reset zero-fill has completed
//   dbg_state  current FSM state (0 = INIT, 1 = RUN)
//
// Access protocol: there is no handshake. Every rising edge in RUN performs
// exactly one access: a write when WE = 1, otherwise a read. The result is on
// data_out after that same edge. Accesses presented while Init_Done = 0 are
// ignored.

module lbm_moment_ram #(
  parameter int DEPTH         = 256,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH    = 32
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         WE,
  input  logic [ADDRESS_WIDTH-1:0]     address,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         Init_Done,
  output logic                         dbg_state
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // One extra bit so that the range check also works when DEPTH is exactly
  // 2**ADDRESS_WIDTH.
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                  state;
  state_t                  state_next;
  logic [ADDRESS_WIDTH-1:0] sweep_ptr;
  logic                    sweep_last;
  logic                    addr_ok;

  // Shared memory write port, muxed between the zero-fill sweep and the
  // external interface.
  logic                    mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // No reset on the array so it maps onto block RAM.
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  assign addr_ok    = ({1'b0, address} < DEPTH_EXT);
  assign sweep_last = (sweep_ptr == LAST_ADDR);
  assign Init_Done  = (state == S_RUN);
  assign dbg_state  = state;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state and memory port control
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_addr   = address;
    mem_wdata  = data_in;
    case (state)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = sweep_ptr;
        mem_wdata = '0;
        if (sweep_last) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Out-of-range writes are dropped instead of aliasing onto low words.
        mem_we = WE && addr_ok;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep pointer: walks 0..DEPTH-1 during INIT, parked in RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sweep_ptr <= '0;
    end else if (state == S_INIT && !sweep_last) begin
      sweep_ptr <= sweep_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port (write-first)
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_out <= '0;
    end else if (state != S_RUN || !addr_ok) begin
      data_out <= '0;
    end else if (WE) begin
      data_out <= data_in;
    end else begin
      data_out <= mem[address];
    end
  end

endmodule

// File: tb/tb_lbm_moment_ram.sv
// tb_lbm_moment_ram
// Directed bench for lbm_moment_ram. Driver tasks issue one access per cycle
// and push the hand-computed expected data_out into exp_q; an independent
// monitor pops and compares after every edge that carried an access.
// Init sweep and asynchronous reset behaviour are checked directly.

module tb_lbm_moment_ram;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 WE;
  logic [AW-1:0]        address;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] data_out;
  logic                 Init_Done;
  logic                 dbg_state;

  always #10 Clk = ~Clk;  // 50 MHz

  lbm_moment_ram #(
    .DEPTH(DEPTH),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .WE(WE),
    .address(address),
    .data_in(data_in),
    .data_out(data_out),
    .Init_Done(Init_Done),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  logic          issue = 1'b0;   // high while the driven inputs form a checked access
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge that carried an access produces one data_out word.
  always @(posedge Clk) begin
    if (issue) begin
      #1;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL monitor_underflow: got %h expected none at %0t", data_out, $time);
      end else begin
        check("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic access(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp);
    @(negedge Clk);
    WE      = we;
    address = addr;
    data_in = data;
    issue   = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic idle();
    @(negedge Clk);
    WE    = 1'b0;
    issue = 1'b0;
  endtask

  // Called at a negedge just after Reset is released. Bounded to DEPTH edges.
  task automatic wait_init();
    int bad_done;
    int bad_data;
    bad_done = 0;
    bad_data = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge Clk);
      #1;
      if (Init_Done !== (i == DEPTH - 1)) bad_done++;
      if (data_out !== '0) bad_data++;
    end
    check("init_done_timing_errors", DW'(bad_done), '0);
    check("init_data_out_nonzero", DW'(bad_data), '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset   = 1'b1;
    WE      = 1'b0;
    address = '0;
    data_in = '0;
    #1;
    check("reset_data_out", data_out, '0);
    check("reset_init_done", DW'(Init_Done), '0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    wait_init();

    // Fresh array reads as zero
    access(1'b0, 8'h00, '0, 32'h0);
    access(1'b0, 8'h7F, '0, 32'h0);
    access(1'b0, 8'hFF, '0, 32'h0);

    // Sequential writes with write-through, then read back
    for (int a = 0; a < 4; a++) access(1'b1, AW'(a), 32'h1, 32'h1);
    for (int a = 0; a < 4; a++) access(1'b0, AW'(a), '0, 32'h1);
    access(1'b0, 8'h04, '0, 32'h0);

    // Full-width and negative data
    access(1'b1, 8'h12, 32'h1234_5678, 32'h1234_5678);
    access(1'b1, 8'hFF, 32'hABCC_CDEF, 32'hABCC_CDEF);
    access(1'b0, 8'h12, '0, 32'h1234_5678);
    access(1'b0, 8'hFF, '0, 32'hABCC_CDEF);

    // Read/write interleave on one address
    access(1'b1, 8'h20, 32'hAAAA_0001, 32'hAAAA_0001);
    access(1'b0, 8'h20, '0, 32'hAAAA_0001);
    access(1'b1, 8'h20, 32'hBBBB_0002, 32'hBBBB_0002);
    access(1'b0, 8'h20, '0, 32'hBBBB_0002);
    access(1'b0, 8'h03, '0, 32'h1);

    // Writes held on during the sweep are ignored
    access(1'b1, 8'h05, 32'h5555_5555, 32'h5555_5555);
    idle();
    WE      = 1'b1;
    address = 8'h05;
    data_in = 32'hDEAD_BEEF;
    #2;
    Reset = 1'b1;
    #1;
    check("reset2_data_out", data_out, '0);
    check("reset2_init_done", DW'(Init_Done), '0);
    @(negedge Clk);
    Reset = 1'b0;
    wait_init();
    access(1'b0, 8'h05, '0, 32'h0);
    access(1'b0, 8'h12, '0, 32'h0);

    // Asynchronous reset between clock edges
    access(1'b1, 8'h10, 32'h7, 32'h7);
    idle();                       // WE low, address still 0x10: plain read
    @(posedge Clk);
    #4;
    check("pre_reset_read", data_out, 32'h7);
    Reset = 1'b1;
    #1;
    check("async_reset_data_out", data_out, '0);
    check("async_reset_init_done", DW'(Init_Done), '0);
    @(negedge Clk);
    Reset = 1'b0;
    wait_init();
    access(1'b0, 8'h10, '0, 32'h0);
    access(1'b0, 8'hFF, '0, 32'h0);

    // Drain
    idle();
    repeat (2) @(negedge Clk);
    check("exp_q_leftover", DW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
